// File: rtl/add64_sequencer.sv
// ---------------------------------------------------------------------------
// add64_sequencer
//
// Purpose:
//   64-bit add/subtract unit that reuses a single 16-bit carry-lookahead adder
//   (Adder16) over four consecutive clock cycles, one 16-bit chunk per cycle,
//   least significant chunk first. The carry out of each chunk is registered
//   and fed back as the carry in of the next chunk. Subtraction is done as
//   a + ~b + 1, with the +1 entering as the initial carry.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operand request valid
//   in_ready   out  1   high only in IDLE, request is accepted on that edge
//   a          in   64  first operand
//   b          in   64  second operand
//   sub        in   1   0 = a+b, 1 = a-b
//   out_valid  out  1   high only in DONE
//   out_ready  in   1   consumer accepts the result
//   sum        out  64  result (valid only while out_valid=1)
//   cout       out  1   carry out of bit 63 (subtract: 1 = no borrow)
//   ovf        out  1   two's-complement signed overflow
//   busy       out  1   high in RUN and DONE
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// Adder16
//
// Purpose:
//   16-bit two-level carry-lookahead adder: four 4-bit lookahead groups whose
//   group generate/propagate terms feed a second lookahead level, so no carry
//   ripples through more than one group.
//
// Ports:
//   a     in   16  first addend
//   b     in   16  second addend
//   cin   in   1   carry in
//   sum   out  16  a + b + cin (low 16 bits)
//   cout  out  1   carry out of bit 15
// ---------------------------------------------------------------------------
module Adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] gen;
  logic [15:0] prop;
  logic [3:0]  grp_gen;
  logic [3:0]  grp_prop;
  logic [4:0]  grp_carry;
  logic [15:0] bit_carry;

  // Per-bit generate and propagate terms.
  always_comb begin
    gen  = a & b;
    prop = a ^ b;
  end

  // First level: each 4-bit group reports whether it generates a carry on
  // its own, or would pass an incoming carry straight through.
  always_comb begin
    grp_gen  = '0;
    grp_prop = '0;
    for (int k = 0; k < 4; k++) begin
      grp_gen[k]  = gen[4*k+3]
                  | (prop[4*k+3] & gen[4*k+2])
                  | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                  | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
      grp_prop[k] = prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & prop[4*k];
    end
  end

  // Second level: carry into every group is computed directly from cin and
  // the group terms, so the group carries are all produced in parallel.
  always_comb begin
    grp_carry[0] = cin;
    grp_carry[1] = grp_gen[0] | (grp_prop[0] & cin);
    grp_carry[2] = grp_gen[1]
                 | (grp_prop[1] & grp_gen[0])
                 | (grp_prop[1] & grp_prop[0] & cin);
    grp_carry[3] = grp_gen[2]
                 | (grp_prop[2] & grp_gen[1])
                 | (grp_prop[2] & grp_prop[1] & grp_gen[0])
                 | (grp_prop[2] & grp_prop[1] & grp_prop[0] & cin);
    grp_carry[4] = grp_gen[3]
                 | (grp_prop[3] & grp_gen[2])
                 | (grp_prop[3] & grp_prop[2] & grp_gen[1])
                 | (grp_prop[3] & grp_prop[2] & grp_prop[1] & grp_gen[0])
                 | (grp_prop[3] & grp_prop[2] & grp_prop[1] & grp_prop[0] & cin);
  end

  // Inside each group, the carry into every bit is expanded from the group
  // carry in, again without rippling from bit to bit.
  always_comb begin
    bit_carry = '0;
    for (int k = 0; k < 4; k++) begin
      bit_carry[4*k]   = grp_carry[k];
      bit_carry[4*k+1] = gen[4*k] | (prop[4*k] & grp_carry[k]);
      bit_carry[4*k+2] = gen[4*k+1]
                       | (prop[4*k+1] & gen[4*k])
                       | (prop[4*k+1] & prop[4*k] & grp_carry[k]);
      bit_carry[4*k+3] = gen[4*k+2]
                       | (prop[4*k+2] & gen[4*k+1])
                       | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                       | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & grp_carry[k]);
    end
  end

  // Sum bits and the final carry out.
  always_comb begin
    sum  = prop ^ bit_carry;
    cout = grp_carry[4];
  end

endmodule

module add64_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] sum,
  output logic        cout,
  output logic        ovf,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] a_reg;
  logic [63:0] beff_reg;
  logic        carry;
  logic [1:0]  idx;

  logic [15:0] chunk_a;
  logic [15:0] chunk_b;
  logic [15:0] chunk_sum;
  logic        chunk_cout;

  // Select the operand chunk for the current step. Chunk 0 is the least
  // significant 16 bits, so carries flow upward from one step to the next.
  always_comb begin
    chunk_a = a_reg[15:0];
    chunk_b = beff_reg[15:0];
    case (idx)
      2'd0: begin
        chunk_a = a_reg[15:0];
        chunk_b = beff_reg[15:0];
      end
      2'd1: begin
        chunk_a = a_reg[31:16];
        chunk_b = beff_reg[31:16];
      end
      2'd2: begin
        chunk_a = a_reg[47:32];
        chunk_b = beff_reg[47:32];
      end
      default: begin
        chunk_a = a_reg[63:48];
        chunk_b = beff_reg[63:48];
      end
    endcase
  end

  // The one and only adder in the datapath, shared across all four chunks.
  Adder16 u_adder (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // Control FSM plus all datapath registers. The handshake flags are kept as
  // registers that change together with the state so the outputs are clean.
  // On the last step the final carry and the signed overflow are captured;
  // overflow uses the top bit of the chunk-3 result, which is sum[63].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      beff_reg  <= '0;
      carry     <= 1'b0;
      idx       <= 2'd0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            beff_reg <= sub ? ~b : b;
            carry    <= sub;
            idx      <= 2'd0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        RUN: begin
          case (idx)
            2'd0:    sum[15:0]  <= chunk_sum;
            2'd1:    sum[31:16] <= chunk_sum;
            2'd2:    sum[47:32] <= chunk_sum;
            default: sum[63:48] <= chunk_sum;
          endcase
          carry <= chunk_cout;
          if (idx == 2'd3) begin
            cout      <= chunk_cout;
            ovf       <= (a_reg[63] == beff_reg[63]) && (chunk_sum[15] != a_reg[63]);
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 2'd1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/add64_sequencer.md
ADD64_SEQUENCER -- requirements
Module: add64_sequencer

Interface
REQ-001 The block SHALL have no parameters: width fixed at 64 bits, 4 chunks of 16 bits.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept an operand request.
REQ-007 a  input  64  first operand.
REQ-008 b  input  64  second operand.
REQ-009 sub  input  1  0 = a+b, 1 = a-b.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  64  result.
REQ-013 cout  output  1  final carry out of bit 63; for subtract, 1 = no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The block SHALL instantiate exactly one Adder16, 16-bit CLA, and time-share it across the four 16-bit chunks; no other adder SHALL exist in the datapath.
REQ-017 The FSM SHALL have states IDLE, RUN, DONE.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 out_valid SHALL be 1 only in DONE.
REQ-020 Accept: in IDLE with in_valid=1 at a clock edge, the block SHALL register a, b_eff = sub ? ~b : b, carry = sub, and chunk index = 0, and SHALL enter RUN.
REQ-021 In RUN, each cycle the Adder16 SHALL add a[16i+15:16i] and b_eff[16i+15:16i] with cin = carry register.
REQ-022 At each RUN edge, the Adder16 sum SHALL be written to sum[16i+15:16i], cout SHALL be written to the carry register, and i SHALL increment.
REQ-023 When i = 3, the block SHALL enter DONE instead of incrementing.
REQ-024 Latency SHALL be exactly 4 clocks: out_valid SHALL rise at the 4th edge after the accepting edge.
REQ-025 At the DONE entry edge, cout SHALL equal the chunk-3 carry out.
REQ-026 At the DONE entry edge, ovf SHALL be (a[63] == b_eff[63]) && (sum[63] != a[63]).
REQ-027 In DONE, an edge with out_ready=1 SHALL complete the transfer and return the FSM to IDLE.
REQ-028 In DONE with out_ready=0, sum, cout, ovf and out_valid SHALL hold indefinitely.
REQ-029 in_valid, a, b and sub SHALL be ignored outside IDLE; operands registered at accept SHALL NOT change until the next accept.
REQ-030 sum, cout and ovf SHALL hold their last values in IDLE and RUN; sum chunks update progressively during RUN and are valid only while out_valid=1.
REQ-031 out_ready is don't-care outside DONE.
REQ-032 Minimum issue interval SHALL be 6 clocks: accept, 4 RUN, DONE with out_ready=1, then back to IDLE.

Reset
REQ-033 Asserting rst_n=0 in any state SHALL immediately force FSM=IDLE, index=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0 and busy=0.
REQ-034 During reset, in_ready SHALL be 1 once in IDLE.
REQ-035 An operation in flight at reset SHALL be discarded with no out_valid pulse.
REQ-036 The first edge after rst_n deassertion SHALL accept a new request if in_valid=1.

Verification
REQ-037 a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> 4 clocks after accept: sum=0, cout=1, ovf=0 (carry ripples through all 4 chunks).
REQ-038 a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
REQ-039 a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0; then a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-040 a=0x0000_0000_0000_FFFF, b=1, sub=0 -> sum=0x0000_0000_0001_0000 (chunk-boundary carry), cout=0.
REQ-041 Backpressure: hold out_ready=0 for 10 clocks in DONE while toggling in_valid, a and b -> sum, cout and ovf stable, in_ready=0, no second accept; out_ready=1 -> IDLE next edge.
REQ-042 Assert rst_n=0 two clocks into RUN -> all outputs 0, no out_valid; after release, a=3, b=4 -> sum=7 after 4 clocks.
